// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC/NPC exchange, imem req/ack port and downstream valid/ready port.
interface fetch_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc_in;
  logic            redirect;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            fetch_err;

  // Sequencer side
  modport master (
    output pc, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    input  npc_in, redirect, imem_ack, imem_rdata, inst_ready
  );

  // Core/memory side
  modport slave (
    input  pc, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    output npc_in, redirect, imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, runs the imem req/ack handshake and
// presents fetched words downstream with valid/ready.
// Optional feature: define DELAY_SLOT_EN to defer redirects past one delay-slot instruction.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic            req_q, req_n;
  logic            valid_q, valid_n;
  logic [XLEN-1:0] inst_q, inst_n;
  logic [XLEN-1:0] ipc_q, ipc_n;
  logic            err_q, err_n;
  logic [CNT_W-1:0] wcnt_q, wcnt_n;

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] accept_pc;
  logic            rd_now;

`ifdef DELAY_SLOT_EN
  logic            pend_vld_q, pend_vld_n;
  logic            pend_skip_q, pend_skip_n;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_n;
`endif

  assign bus.pc         = pc_q;
  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.fetch_err  = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    addr_n  = addr_q;
    valid_n = valid_q;
    inst_n  = inst_q;
    ipc_n   = ipc_q;
    err_n   = err_q;
    wcnt_n  = '0;
    tgt     = {bus.npc_in[XLEN-1:2], 2'b00};
    pc_inc  = pc_q + XLEN'(4);
`ifdef DELAY_SLOT_EN
    pend_vld_n  = pend_vld_q;
    pend_skip_n = pend_skip_q;
    pend_tgt_n  = pend_tgt_q;
    rd_now      = 1'b0;
    // The pending target replaces pc+4 only when the delay slot itself is accepted
    accept_pc   = (pend_vld_q && !pend_skip_q) ? pend_tgt_q : pc_inc;
`else
    rd_now      = bus.redirect;
    accept_pc   = pc_inc;
`endif

    case (state_q)
      IDLE: begin
        if (rd_now) pc_n = tgt;
        addr_n  = rd_now ? tgt : pc_q;
        state_n = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          if (rd_now) begin
            pc_n   = tgt;
            addr_n = tgt;
          end else begin
            inst_n  = bus.imem_rdata;
            ipc_n   = addr_q;
            valid_n = 1'b1;
            state_n = HOLD;
          end
        end else if (rd_now) begin
          pc_n    = tgt;
          state_n = KILL;
        end
      end
      HOLD: begin
        if (rd_now) begin
          pc_n    = tgt;
          valid_n = 1'b0;
          addr_n  = tgt;
          state_n = FETCH;
        end else if (bus.inst_ready) begin
          pc_n    = accept_pc;
          valid_n = 1'b0;
          addr_n  = accept_pc;
          state_n = FETCH;
        end
      end
      KILL: begin
        // A redirect coinciding with the ack retargets the follow-up fetch directly
        if (rd_now) pc_n = tgt;
        if (bus.imem_ack) begin
          addr_n  = pc_n;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef DELAY_SLOT_EN
    // Consume the pending redirect first, then latch any new one
    if (state_q == HOLD && bus.inst_ready && pend_vld_q) begin
      if (pend_skip_q) pend_skip_n = 1'b0;
      else             pend_vld_n  = 1'b0;
    end
    if (bus.redirect) begin
      pend_tgt_n = tgt;
      if (!pend_vld_n) begin
        pend_vld_n  = 1'b1;
        // Redirect seen while the transfer itself is still held: skip its own acceptance
        pend_skip_n = (state_q == HOLD) && !bus.inst_ready;
      end
    end
`endif

    // Ack timeout: count request cycles without ack, saturate, raise sticky error
    if ((state_q == FETCH || state_q == KILL) && !bus.imem_ack) begin
      if (wcnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
        err_n  = 1'b1;
        wcnt_n = wcnt_q;
      end else begin
        wcnt_n = wcnt_q + CNT_W'(1);
      end
    end

    req_n = (state_n == FETCH) || (state_n == KILL);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`ifdef DELAY_SLOT_EN
      pend_vld_q  <= 1'b0;
      pend_skip_q <= 1'b0;
      pend_tgt_q  <= '0;
`endif
    end else begin
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      valid_q <= valid_n;
      inst_q  <= inst_n;
      ipc_q   <= ipc_n;
      err_q   <= err_n;
      wcnt_q  <= wcnt_n;
`ifdef DELAY_SLOT_EN
      pend_vld_q  <= pend_vld_n;
      pend_skip_q <= pend_skip_n;
      pend_tgt_q  <= pend_tgt_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared every cycle against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int unsigned ACK_TIMEOUT = 16;
  localparam logic [31:0] RESET_PC    = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC, one outstanding request, one held instruction
  logic [31:0] m_pc, m_addr, m_inst, m_ipc;
  logic        m_req, m_valid, m_err, m_stale;
  int          m_miss;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_ptgt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_addr = '0; m_inst = '0; m_ipc = '0;
    m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_stale = 1'b0; m_miss = 0;
    m_pend = 1'b0; m_cnt = 0; m_ptgt = '0;
  endtask

  task automatic model_update(input logic a, input logic rdy, input logic rd, input logic [31:0] npc);
    logic [31:0] tgt, n_pc;
    logic        acc, rd_now;
    tgt = {npc[31:2], 2'b00};
`ifdef DELAY_SLOT_EN
    rd_now = 1'b0;
    acc    = m_valid && rdy;
    n_pc   = m_pc;
    if (acc) begin
      if (m_pend && m_cnt == 1) begin
        n_pc   = m_ptgt;
        m_pend = 1'b0;
      end else begin
        n_pc = m_pc + 32'd4;
        if (m_pend) m_cnt = m_cnt - 1;
      end
    end
    if (rd) begin
      m_ptgt = tgt;
      if (!m_pend) begin
        m_pend = 1'b1;
        // acceptances still to come before the jump: the transfer (if held) and its slot
        m_cnt  = (m_valid ? 2 : 1) - (acc ? 1 : 0);
      end
    end
`else
    rd_now = rd;
    acc    = m_valid && rdy && !rd;
    n_pc   = rd ? tgt : (acc ? m_pc + 32'd4 : m_pc);
`endif
    if (m_req) begin
      if (a) begin
        m_miss = 0;
        if (m_stale || rd_now) begin
          m_addr  = n_pc;
          m_stale = 1'b0;
        end else begin
          m_req   = 1'b0;
          m_valid = 1'b1;
          m_inst  = mem(m_addr);
          m_ipc   = m_addr;
        end
      end else begin
        m_miss = m_miss + 1;
        if (m_miss >= int'(ACK_TIMEOUT)) m_err = 1'b1;
        if (rd_now) m_stale = 1'b1;
      end
    end else if (m_valid) begin
      m_miss = 0;
      if (rd_now || acc) begin
        m_valid = 1'b0;
        m_req   = 1'b1;
        m_addr  = n_pc;
      end
    end else begin
      m_miss = 0;
      m_req  = 1'b1;
      m_addr = n_pc;
    end
    m_pc = n_pc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc",         bus.pc,               m_pc);
    chk("imem_req",   32'(bus.imem_req),    32'(m_req));
    chk("imem_addr",  bus.imem_addr,        m_addr);
    chk("inst_valid", 32'(bus.inst_valid),  32'(m_valid));
    chk("inst",       bus.inst,             m_inst);
    chk("inst_pc",    bus.inst_pc,          m_ipc);
    chk("fetch_err",  32'(bus.fetch_err),   32'(m_err));
  endtask

  // One clock cycle: drive inputs, advance model, compare on the falling edge
  task automatic step(input logic ack, input logic rdy, input logic rd, input logic [31:0] npc);
    logic a;
    a = ack & m_req;
    bus.imem_ack   = a;
    bus.inst_ready = rdy;
    bus.redirect   = rd;
    bus.npc_in     = npc;
    bus.imem_rdata = mem(bus.imem_addr);
    model_update(a, rdy, rd, npc);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.redirect = 1'b0;
    bus.npc_in = '0; bus.imem_rdata = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  // Run with ack/ready until a request for addr is presented, bounded by budget
  task automatic run_to(input string tag, input logic [31:0] addr, input int budget);
    logic found;
    int   n;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      if (bus.imem_req && bus.imem_addr === addr) found = 1'b1;
      else begin
        step(1'b1, 1'b1, 1'b0, '0);
        n = n + 1;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int ack_pct;
    bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.redirect = 1'b0;
    bus.npc_in = '0; bus.imem_rdata = '0;

    // Reset and sequential fetch with prompt acks
    do_reset(2);
    chk("rst_pc", bus.pc, 32'h0000_3000);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t1_addr0", bus.imem_addr, 32'h0000_3000);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t1_ipc0", bus.inst_pc, 32'h0000_3000);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t1_addr1", bus.imem_addr, 32'h0000_3004);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t1_addr2", bus.imem_addr, 32'h0000_3008);
    chk("t1_err", 32'(bus.fetch_err), 32'd0);

    // Downstream stall in HOLD
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("t2_ipc", bus.inst_pc, 32'h0000_3008);
      chk("t2_req", 32'(bus.imem_req), 32'd0);
      chk("t2_pc",  bus.pc, 32'h0000_3008);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t2_next", bus.imem_addr, 32'h0000_300C);

    // Redirect during an outstanding fetch, ack three cycles later
    step(1'b0, 1'b1, 1'b1, 32'h0000_3043);
    chk("t3_hold_addr", bus.imem_addr, 32'h0000_300C);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("t3_addr", bus.imem_addr, 32'h0000_300C);
      chk("t3_valid", 32'(bus.inst_valid), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
`ifndef DELAY_SLOT_EN
    chk("t3_new_addr", bus.imem_addr, 32'h0000_3040);
    chk("t3_no_valid", 32'(bus.inst_valid), 32'd0);

    // Redirect and inst_ready together in HOLD
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_4000);
    chk("t4_valid", 32'(bus.inst_valid), 32'd0);
    chk("t4_addr", bus.imem_addr, 32'h0000_4000);
`endif

    // Ack withheld until timeout
    do_reset(1);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < int'(ACK_TIMEOUT); i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("t5_req", 32'(bus.imem_req), 32'd1);
    end
    chk("t5_err", 32'(bus.fetch_err), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t5_sticky", 32'(bus.fetch_err), 32'd1);

`ifdef DELAY_SLOT_EN
    // Delay slot: redirect while holding 0x3010
    do_reset(1);
    run_to("t6_reach", 32'h0000_3010, 20);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_5000);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("t6_slot", bus.inst_pc, 32'h0000_3014);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t6_target", bus.imem_addr, 32'h0000_5000);
`endif

    // PC wrap-around at the top of the address space
    do_reset(1);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_to("wrap_top", 32'hFFFF_FFFC, 20);
    run_to("wrap_zero", 32'h0000_0000, 20);

    // Randomized traffic with phases of fast, medium and very slow memory
    do_reset(1);
    for (int ph = 0; ph < 30; ph++) begin
      case (ph % 3)
        0:       ack_pct = 90;
        1:       ack_pct = 50;
        default: ack_pct = 4;
      endcase
      if (ph == 16) do_reset(1);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(99, 0) < 32'(ack_pct)),
             ($urandom_range(3, 0) != 0),
             ($urandom_range(15, 0) == 0),
             $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
